// File: rtl/qpsk_symbol_sampler_if.sv
// rtl/qpsk_symbol_sampler_if.sv - stream bundle for the symbol sampler input and output
interface qpsk_symbol_sampler_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/qpsk_symbol_sampler.sv
// rtl/qpsk_symbol_sampler.sv - symbol-rate decimator with FWFT FIFO and packet framing
module qpsk_symbol_sampler #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 4,
  parameter int SPS_W   = 8,
  parameter int LEN_W   = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst_n,
  input  logic                 clear,
  input  logic [1:0]           cfg_mode,
  input  logic [SPS_W-1:0]     cfg_sps,
  input  logic [SPS_W-1:0]     cfg_phase,
  input  logic [LEN_W-1:0]     cfg_pkt_len,
  input  logic                 ext_strobe,
  qpsk_symbol_sampler_if.slave  s,
  qpsk_symbol_sampler_if.master m,
  output logic [15:0]          overflow_cnt,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int W     = 2 * DATA_W;

  logic [1:0]         rst_sync;
  logic               rst_n_i;
  logic [SPS_W-1:0]   cnt;
  logic [SPS_W-1:0]   sps_eff;
  logic [SPS_W-1:0]   sps_last;
  logic [SPS_W-1:0]   phase_eff;
  logic [LEN_W-1:0]   pc;
  logic               pending;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [W:0]         mem [DEPTH];
  logic               is_pass;
  logic               is_count;
  logic               is_ext;
  logic               full;
  logic               empty;
  logic               rd;
  logic               wr_ok;
  logic               beat;
  logic               sel;
  logic               wr;
  logic               drop;
  logic               last_flag;
  logic               unused_tlast;

  // Input tlast carries no meaning here; framing is regenerated locally.
  assign unused_tlast = s.tlast;

  // Reset asserts asynchronously, releases two edges after ce_rst_n rises.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign is_pass  = (cfg_mode == 2'd0) || (cfg_mode == 2'd3);
  assign is_count = (cfg_mode == 2'd1);
  assign is_ext   = (cfg_mode == 2'd2);

  assign sps_eff   = (cfg_sps < SPS_W'(2)) ? SPS_W'(1) : cfg_sps;
  assign sps_last  = sps_eff - SPS_W'(1);
  assign phase_eff = (cfg_phase > sps_last) ? sps_last : cfg_phase;

  assign full    = (fifo_level == (FIFO_AW+1)'(DEPTH));
  assign empty   = (fifo_level == '0);
  assign m.tvalid = !empty;
  assign m.tdata  = mem[rd_ptr][W-1:0];
  assign m.tlast  = mem[rd_ptr][W];
  assign rd      = m.tvalid && m.tready;
  assign wr_ok   = !full || rd;

  // PASS backpressures through the FIFO; the real-time modes never stall the source.
  assign s.tready = rst_n_i && (is_pass ? wr_ok : 1'b1);
  assign beat     = s.tvalid && s.tready;

  // Pick which accepted beats become symbols.
  always_comb begin
    sel = 1'b0;
    if (is_pass)       sel = beat;
    else if (is_count) sel = beat && (cnt == phase_eff);
    else if (is_ext)   sel = beat && (ext_strobe || pending);
  end

  assign wr        = sel && wr_ok && !clear;
  assign drop      = sel && !wr_ok && !clear;
  // >= keeps a packet bounded if cfg_pkt_len shrinks below the running count.
  assign last_flag = (cfg_pkt_len != '0) && (pc >= cfg_pkt_len - LEN_W'(1));

  // Samples-per-symbol counter; the >= compare handles a live shrink of cfg_sps.
  always_ff @(posedge ce_clk or negedge rst_n_i) begin
    if (!rst_n_i)   cnt <= '0;
    else if (clear) cnt <= '0;
    else if (beat)  cnt <= (cnt >= sps_last) ? '0 : cnt + SPS_W'(1);
  end

  // Remember a strobe that arrived with no beat so the next beat is taken.
  always_ff @(posedge ce_clk or negedge rst_n_i) begin
    if (!rst_n_i)          pending <= 1'b0;
    else if (clear || !is_ext) pending <= 1'b0;
    else if (beat)         pending <= 1'b0;
    else if (ext_strobe)   pending <= 1'b1;
  end

  // Packet position counter, advanced only by symbols actually stored.
  always_ff @(posedge ce_clk or negedge rst_n_i) begin
    if (!rst_n_i)   pc <= '0;
    else if (clear) pc <= '0;
    else if (wr)    pc <= last_flag ? '0 : pc + LEN_W'(1);
  end

  // Ring buffer storage and pointers; a write on a full read cycle reuses the freed slot.
  always_ff @(posedge ce_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= {last_flag, s.tdata};
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (wr && !rd)      fifo_level <= fifo_level + (FIFO_AW+1)'(1);
      else if (rd && !wr) fifo_level <= fifo_level - (FIFO_AW+1)'(1);
    end
  end

  // Saturating count of selected symbols lost to a full FIFO.
  always_ff @(posedge ce_clk or negedge rst_n_i) begin
    if (!rst_n_i)                           overflow_cnt <= '0;
    else if (clear)                         overflow_cnt <= '0;
    else if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
  end

endmodule

// File: tb/tb_qpsk_symbol_sampler.sv
// tb/tb_qpsk_symbol_sampler.sv - directed scoreboard bench for qpsk_symbol_sampler
module tb_qpsk_symbol_sampler;

  logic        ce_clk;
  logic        ce_rst_n;
  logic        clear;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_sps;
  logic [7:0]  cfg_phase;
  logic [15:0] cfg_pkt_len;
  logic        ext_strobe;
  logic [15:0] overflow_cnt;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [32:0] exp_q [$];

  qpsk_symbol_sampler_if #(.W(32)) s_if ();
  qpsk_symbol_sampler_if #(.W(32)) m_if ();

  qpsk_symbol_sampler #(.DATA_W(16), .FIFO_AW(2), .SPS_W(8), .LEN_W(16)) dut (
    .ce_clk       (ce_clk),
    .ce_rst_n     (ce_rst_n),
    .clear        (clear),
    .cfg_mode     (cfg_mode),
    .cfg_sps      (cfg_sps),
    .cfg_phase    (cfg_phase),
    .cfg_pkt_len  (cfg_pkt_len),
    .ext_strobe   (ext_strobe),
    .s            (s_if.slave),
    .m            (m_if.master),
    .overflow_cnt (overflow_cnt),
    .fifo_level   (fifo_level)
  );

  initial ce_clk = 1'b0;
  always #5 ce_clk = ~ce_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    tick();
    s_if.tvalid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Output scoreboard: every handshake must match the oldest expected symbol.
  always @(negedge ce_clk) begin
    if (ce_rst_n && m_if.tvalid && m_if.tready) begin
      logic [32:0] e;
      n_out++;
      chk("out_expected_present", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", m_if.tdata, e[31:0]);
        chk("out_last", m_if.tlast, e[32]);
      end
    end
  end

  initial begin
    int lvl;
    int nxt;
    int n0;
    logic ok;
    ce_rst_n    = 1'b1;
    clear       = 1'b0;
    cfg_mode    = 2'd0;
    cfg_sps     = 8'd1;
    cfg_phase   = 8'd0;
    cfg_pkt_len = 16'd0;
    ext_strobe  = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    #1 ce_rst_n = 1'b0;

    // Reset state
    tick();
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow_cnt, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    tick();
    chk("rel_ready_edge1", s_if.tready, 0);
    tick();
    chk("rel_ready_edge2", s_if.tready, 1);

    // COUNT mode sps=4 phase=2
    cfg_mode = 2'd1; cfg_sps = 8'd4; cfg_phase = 8'd2; cfg_pkt_len = 16'd0;
    m_if.tready = 1'b1;
    do_clear();
    for (int i = 0; i < 16; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'(i);
      s_if.tlast  = 1'(i % 2);
      if (i % 4 == 2) exp_q.push_back({1'b0, 32'(i)});
      tick();
      chk("count_valid", m_if.tvalid, (i % 4 == 2));
      if (i % 4 == 2) chk("count_lat_data", m_if.tdata, i);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    drain("count_drain");

    // Packet framing, PASS, pkt_len=3, 7 beats
    cfg_mode = 2'd0; cfg_pkt_len = 16'd3;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({(i == 2 || i == 5), 32'h700 + 32'(i)});
      beat(32'h700 + 32'(i));
    end
    drain("frame_drain");

    // EXT mode: strobe without beat, two more strobes, then beats
    cfg_mode = 2'd2; cfg_pkt_len = 16'd0;
    do_clear();
    ext_strobe = 1'b1;
    tick();
    tick();
    tick();
    ext_strobe = 1'b0;
    n0 = n_out;
    exp_q.push_back({1'b0, 32'h1234});
    beat(32'h1234);
    beat(32'h5555);
    beat(32'h6666);
    drain("ext_drain");
    tick();
    chk("ext_one_symbol", n_out - n0, 1);

    // Overflow: COUNT sps=1, no reads, 10 beats into depth 4
    cfg_mode = 2'd1; cfg_sps = 8'd1; cfg_phase = 8'd0;
    m_if.tready = 1'b0;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) exp_q.push_back({1'b0, 32'(i)});
      beat(32'(i));
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_count", overflow_cnt, 6);
    chk("ovf_head", m_if.tdata, 0);
    m_if.tready = 1'b1;
    drain("ovf_drain");

    // Clear with 3 symbols queued and a nonzero overflow count
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) beat(32'h30 + 32'(i));
    chk("clr_level_before", fifo_level, 3);
    chk("clr_ovf_before", overflow_cnt, 6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_level", fifo_level, 0);
    chk("clr_ovf", overflow_cnt, 0);
    chk("clr_tvalid", m_if.tvalid, 0);

    // PASS backpressure with toggling m_tready
    cfg_mode = 2'd0; cfg_pkt_len = 16'd0;
    do_clear();
    lvl = 0;
    nxt = 0;
    for (int c = 0; c < 24; c++) begin
      m_if.tready = (c % 2 == 0);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h100 + 32'(nxt);
      @(negedge ce_clk);
      ok = (lvl < 4) || (lvl > 0 && m_if.tready);
      chk("pass_ready", s_if.tready, ok);
      if (ok) begin
        exp_q.push_back({1'b0, 32'h100 + 32'(nxt)});
        nxt++;
      end
      lvl = lvl + (ok ? 1 : 0) - ((lvl > 0 && m_if.tready) ? 1 : 0);
      tick();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    drain("pass_drain");

    // Asynchronous reset mid-stream
    cfg_mode = 2'd1; cfg_sps = 8'd1; cfg_pkt_len = 16'd3;
    m_if.tready = 1'b0;
    do_clear();
    for (int i = 0; i < 6; i++) beat(32'hA0 + 32'(i));
    chk("pre_rst_level", fifo_level, 4);
    chk("pre_rst_ovf", overflow_cnt, 2);
    chk("pre_rst_data", m_if.tdata, 32'hA0);
    #3;
    ce_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_m_tvalid", m_if.tvalid, 0);
    chk("arst_m_tlast", m_if.tlast, 0);
    chk("arst_m_tdata", m_if.tdata, 0);
    chk("arst_s_tready", s_if.tready, 0);
    chk("arst_overflow", overflow_cnt, 0);
    chk("arst_level", fifo_level, 0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    tick();
    chk("arel_ready_edge1", s_if.tready, 0);
    tick();
    chk("arel_ready_edge2", s_if.tready, 1);

    // Next packet after reset starts at pc=0
    cfg_mode = 2'd0; cfg_pkt_len = 16'd2;
    m_if.tready = 1'b1;
    exp_q.push_back({1'b0, 32'hB0});
    exp_q.push_back({1'b1, 32'hB1});
    beat(32'hB0);
    beat(32'hB1);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_sampler.md
# qpsk_symbol_sampler

- Parametrised symbol-rate decimator between the carrier-recovery stage and the AXI wrapper output of the QPSK demodulator.
- Takes recovered I/Q samples at the sample rate and selects one sample per symbol.
  - Selection comes from an internal samples-per-symbol counter or an external bit-sync strobe; a pass-through mode selects every sample.
- Selected symbols are buffered in a FIFO and emitted as properly handshaked AXI-stream packets of programmable length.
- Overflow is reported instead of violating the handshake.

## Interface

Parameters:
- DATA_W, 16, width of each of I and Q
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW symbols
- SPS_W, 8, width of the samples-per-symbol and phase fields
- LEN_W, 16, width of the packet-length field

Ports:
- ce_clk  in  1  single clock
- ce_rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of FIFO, counters, pending strobe and overflow_cnt
- cfg_mode  in  2  0=PASS, 1=COUNT, 2=EXT, 3=treated as PASS
- cfg_sps  in  SPS_W  samples per symbol; values 0 and 1 both mean 1
- cfg_phase  in  SPS_W  sampling phase within the symbol for COUNT mode
- cfg_pkt_len  in  LEN_W  symbols per output packet; 0 = never assert tlast
- ext_strobe  in  1  bit-sync pulse for EXT mode
- s_tdata  in  2*DATA_W  {I,Q}
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  2*DATA_W  selected {I,Q}
- m_tlast  out  1  last symbol of packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- overflow_cnt  out  16  dropped-symbol count, saturating
- fifo_level  out  FIFO_AW+1  current FIFO occupancy

## Operation

**Beats**
- An accepted beat is a cycle with s_tvalid && s_tready.
- wr_ok = !full || (m_tvalid && m_tready).

**Ready behaviour**
- PASS: s_tready = wr_ok. Every accepted beat is selected, so there is no loss and backpressure propagates.
- COUNT and EXT: s_tready = 1 at all times (real-time stream). A selected beat is written if wr_ok; otherwise it is dropped and overflow_cnt increments, saturating at 0xFFFF.

**COUNT mode**
- Counter cnt advances on each accepted beat and wraps from sps_eff-1 to 0.
- A beat is selected when cnt == phase_eff.
- phase_eff = min(cfg_phase, sps_eff-1).

**EXT mode**
- A beat accepted in a cycle with ext_strobe=1 is selected.
- A strobe with no accepted beat sets `pending`; the next accepted beat is then selected and `pending` clears.
- Multiple strobes while `pending` is set merge into a single selection.

**Packet framing**
- Packet counter pc increments on each symbol written to the FIFO.
- tlast is stored with the symbol when pc == cfg_pkt_len-1; pc then resets to 0.
- Dropped symbols do not advance pc.
- Input tlast is ignored.

**FIFO**
- Standard ring buffer with first-word-fall-through output.
- fifo_level is updated on the same edge as each write or read.

**Configuration changes**
- Configuration inputs are used live.
- A change to cfg_sps reaches the wrap point immediately: if cnt >= new sps_eff, cnt wraps to 0 on the next beat.
- Software must pulse clear after a mode change.

**clear**
- Zeroes cnt, pc, pending, FIFO pointers and overflow_cnt. It has no effect on the configuration inputs.
- If clear and a write occur in the same cycle, the write is discarded.

## Timing

**Reset**
- ce_rst_n low drives these outputs to 0 immediately (asynchronously): m_tvalid, m_tlast, m_tdata, s_tready, overflow_cnt, fifo_level.
- All internal state is zeroed.
- Reset release is synchronised internally. s_tready may rise on the second ce_clk edge after deassertion.

**Latency and handshake**
- A beat selected at edge N appears on m_tdata with m_tvalid=1 after edge N, i.e. in the following cycle, when the FIFO was empty.
- m_tdata and m_tlast hold stable while m_tvalid && !m_tready.

**Full and empty**
- Full with a simultaneous read: the write is accepted and fifo_level is unchanged.
- Full with no read: COUNT/EXT drop and count; PASS deasserts s_tready.
- Empty: m_tvalid=0. A read is never performed while empty.

**Counter behaviour**
- cnt and pc wrap without glitching; there is no bubble at the wrap.
- Reset asserted mid-packet discards the partial packet. The next packet starts at pc=0.

## Test plan

- **COUNT mode:** sps=4, phase=2, m_tready=1, stream s_tdata=0..15. Required: output 2,6,10,14, each one cycle after its input beat.
- **Packet framing:** pkt_len=3 in PASS mode, stream 7 beats. Required: tlast on the symbols at index 2 and 5; index 6 is held without tlast.
- **EXT mode:** ext_strobe in a cycle with s_tvalid=0, then two strobes before the next beat. Required: exactly one symbol, equal to the next beat's data.
- **Overflow:** FIFO_AW=2, COUNT mode with sps=1, m_tready=0, 10 beats. Required: fifo_level=4, overflow_cnt=6, data 0..3 retained. Then raise m_tready: output 0,1,2,3 in order.
- **PASS backpressure:** m_tready toggling 1/0. Required: no loss, no duplicates, s_tready tracks wr_ok.
- **Reset and clear:** assert ce_rst_n low asynchronously mid-stream. Required: all outputs 0 without a clock edge. A clear pulse with 3 symbols queued gives fifo_level=0 next cycle and overflow_cnt=0.
